// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: a free-running tick prescaler drives a lamp-fill
// sequence, a pseudo-random hold, then a single lights-out strobe.
`timescale 1ns/1ps

module f1_light_sequencer #(
    parameter int WIDTH      = 16,
    parameter int NUM_LIGHTS = 8,
    parameter int MIN_HOLD   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      N,
    input  logic                  trigger,
    input  logic                  abort,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  busy,
    output logic                  lights_out_pulse,
    output logic [7:0]            delay_ticks
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [WIDTH-1:0]        cnt, cnt_next;
    logic [6:0]              lfsr;
    logic [7:0]              hold_cnt, hold_next;
    logic [7:0]              hold_load;
    logic [NUM_LIGHTS-1:0]   lights_next, lights_shift;
    logic                    busy_next, pulse_next;
    logic [7:0]              delay_next;
    logic                    tick;
    logic                    bar_full;
    logic                    hold_done;

    assign tick      = en & (cnt == '0);
    assign hold_load = {1'b0, lfsr} + 8'(MIN_HOLD);
    assign bar_full  = &lights_shift;
    assign hold_done = (hold_cnt == 8'd1);

    // One more lamp lit from the bit-0 end; a single-lamp bar just turns on.
    generate
        if (NUM_LIGHTS == 1) begin : g_single
            assign lights_shift = 1'b1;
        end else begin : g_multi
            assign lights_shift = {lights[NUM_LIGHTS-2:0], 1'b1};
        end
    endgenerate

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values, so ordering inside this block is irrelevant.
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            lfsr             <= 7'h01;
            hold_cnt         <= 8'd0;
            lights           <= '0;
            busy             <= 1'b0;
            lights_out_pulse <= 1'b0;
            delay_ticks      <= 8'd0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            lfsr             <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            hold_cnt         <= hold_next;
            lights           <= lights_next;
            busy             <= busy_next;
            lights_out_pulse <= pulse_next;
            delay_ticks      <= delay_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning a default before any branch guarantees no latch is
        // inferred when a branch leaves the signal untouched.
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (trigger) state_next = FILL;
                FILL:    if (tick && bar_full) state_next = HOLD;
                HOLD:    if (tick && hold_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and output next-values.
    always_comb begin
        cnt_next    = cnt;
        lights_next = lights;
        busy_next   = busy;
        pulse_next  = 1'b0;
        hold_next   = hold_cnt;
        delay_next  = delay_ticks;

        // The prescaler free-runs whenever enabled; a trigger re-phases it.
        if (en) begin
            cnt_next = (cnt == '0) ? N : cnt - WIDTH'(1);
        end

        if (abort) begin
            lights_next = '0;
            busy_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        cnt_next    = N;
                        busy_next   = 1'b1;
                        lights_next = '0;
                    end
                end
                FILL: begin
                    if (tick) begin
                        lights_next = lights_shift;
                        if (bar_full) begin
                            hold_next  = hold_load;
                            delay_next = hold_load;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_done) begin
                            lights_next = '0;
                            pulse_next  = 1'b1;
                            busy_next   = 1'b0;
                        end else begin
                            hold_next = hold_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    lights_next = '0;
                    busy_next   = 1'b0;
                end
            endcase
        end
    end

endmodule
